// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage. Owns the PC, captures the instruction
//             word into a 2-entry buffer and hands {instr, pc, pc+4} to decode.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-3:0] imem_addr,
    input  logic [31:0]     imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            id_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [31:0]     instr_q [2];
    logic [31:0]     instr_d [2];
    logic [XLEN-1:0] epc_q   [2];
    logic [XLEN-1:0] epc_d   [2];

    logic w_pop;
    logic w_push;

    assign imem_addr   = pc_q[XLEN-1:2];
    // Redirect masks the handshake so no wrong-path word leaves in that cycle.
    assign if_valid    = (count_q != 2'd0) & ~redirect_valid;
    assign w_pop       = if_valid & id_ready;
    assign w_push      = ~redirect_valid & ((count_q < 2'd2) | w_pop);
    assign if_instr    = instr_q[rd_ptr_q];
    assign if_pc       = epc_q[rd_ptr_q];
    assign if_pc_plus4 = epc_q[rd_ptr_q] + c_pc_step;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        instr_d  = instr_q;
        epc_d    = epc_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (w_push) begin
                instr_d[wr_ptr_q] = imem_rd;
                epc_d[wr_ptr_q]   = pc_q;
                pc_d              = pc_q + c_pc_step;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 2'd1;
            end else if (w_pop && !w_push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            epc_q[0]   <= '0;
            epc_q[1]   <= '0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            instr_q[0] <= instr_d[0];
            instr_q[1] <= instr_d[1];
            epc_q[0]   <= epc_d[0];
            epc_q[1]   <= epc_d[1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit: directed scenarios plus a
//             randomized run against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [29:0] imem_addr,  w_imem_addr;
    logic [31:0] imem_rd,    w_imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid,   w_if_valid;
    logic        id_ready;
    logic [31:0] if_instr,   w_if_instr;
    logic [31:0] if_pc,      w_if_pc;
    logic [31:0] if_pc_plus4, w_if_pc_plus4;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] rom(input logic [29:0] a);
        return 32'h1000_0000 + {2'b00, a};
    endfunction

    assign imem_rd   = rom(imem_addr);
    assign w_imem_rd = rom(w_imem_addr);

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(w_if_valid), .id_ready(id_ready), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ends at a falling edge with reset just released.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = rdy;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 ||
            if_pc_plus4 !== 32'h4 || imem_addr !== 30'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b instr=%h pc=%h pc4=%h addr=%h expected 0/0/0/4/0",
                     if_valid, if_instr, if_pc, if_pc_plus4, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid: got %b expected 0", if_valid);
        end
    endtask

    task automatic test_stream;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) ||
                if_instr !== 32'h1000_0000 + 32'(k) || if_pc_plus4 !== 32'(4 * k + 4)) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b pc=%h instr=%h pc4=%h expected 1/%h/%h/%h",
                         k, if_valid, if_pc, if_instr, if_pc_plus4,
                         32'(4 * k), 32'h1000_0000 + 32'(k), 32'(4 * k + 4));
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (imem_addr !== 30'h2 || if_pc !== 32'h0 || if_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold: addr=%h pc=%h valid=%b expected 2/0/1",
                     imem_addr, if_pc, if_valid);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL backpressure_drain_%0d: valid=%b pc=%h expected 1/%h",
                         k, if_valid, if_pc, 32'(4 * k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect(input logic rdy);
        id_ready = 1'b0;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        id_ready       = rdy;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_t_valid(rdy=%b): got %b expected 0", rdy, if_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 30'h10) begin
            failures++;
            $display("FAIL redirect_t1(rdy=%b): valid=%b addr=%h expected 0/10",
                     rdy, if_valid, imem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1000_0010) begin
            failures++;
            $display("FAIL redirect_t2(rdy=%b): valid=%b pc=%h instr=%h expected 1/40/10000010",
                     rdy, if_valid, if_pc, if_instr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h44) begin
            failures++;
            $display("FAIL redirect_t3(rdy=%b): valid=%b pc=%h expected 1/44", rdy, if_valid, if_pc);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        do_reset(1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC || w_if_pc_plus4 !== 32'h0 ||
            w_if_instr !== 32'h4FFF_FFFF) begin
            failures++;
            $display("FAIL wrap_first: valid=%b pc=%h pc4=%h instr=%h expected 1/fffffffc/0/4fffffff",
                     w_if_valid, w_if_pc, w_if_pc_plus4, w_if_instr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (w_if_valid !== 1'b1 || w_if_pc !== 32'h0 || w_if_pc_plus4 !== 32'h4) begin
            failures++;
            $display("FAIL wrap_second: valid=%b pc=%h pc4=%h expected 1/0/4",
                     w_if_valid, w_if_pc, w_if_pc_plus4);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 30'h2) begin
            failures++;
            $display("FAIL async_pre: valid=%b pc=%h addr=%h expected 1/0/2", if_valid, if_pc, imem_addr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 30'h0) begin
            failures++;
            $display("FAIL async_drop: valid=%b addr=%h expected 0/0", if_valid, imem_addr);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin
            failures++;
            $display("FAIL async_restart: valid=%b pc=%h instr=%h expected 1/0/10000000",
                     if_valid, if_pc, if_instr);
        end
        @(negedge clk);
    endtask

    // Reference model: a queue of {instr, pc} pairs with capacity two.
    task automatic test_random;
        logic [63:0] q[$];
        logic [31:0] m_pc;
        logic        exp_valid;
        logic [63:0] head;
        do_reset(1'b1);
        m_pc = 32'h0;
        q.delete();
        for (int n = 0; n < 400; n++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            #1;
            exp_valid = (q.size() != 0) && !redirect_valid;
            checks++;
            if (if_valid !== exp_valid || imem_addr !== m_pc[31:2]) begin
                failures++;
                $display("FAIL random_ctl_%0d: valid=%b addr=%h expected %b/%h",
                         n, if_valid, imem_addr, exp_valid, m_pc[31:2]);
            end
            if (exp_valid) begin
                head = q[0];
                checks++;
                if (if_instr !== head[63:32] || if_pc !== head[31:0] ||
                    if_pc_plus4 !== head[31:0] + 32'd4) begin
                    failures++;
                    $display("FAIL random_head_%0d: instr=%h pc=%h pc4=%h expected %h/%h/%h",
                             n, if_instr, if_pc, if_pc_plus4, head[63:32], head[31:0],
                             head[31:0] + 32'd4);
                end
            end
            if (redirect_valid) begin
                q.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (exp_valid && id_ready) void'(q.pop_front());
                if (q.size() < 2) begin
                    q.push_back({rom(m_pc[31:2]), m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
